rr_arb2: RTL and testbench
==========================

RR_ARB2 -- requirements
Module: rr_arb2

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the data width of both sources and the output.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port a_valid, input, 1 bit, SHALL indicate source A offers a_data.
REQ-005 Port a_data, input, WIDTH bits, SHALL be source A payload.
REQ-006 Port a_ready, output, 1 bit, SHALL indicate source A is accepted this cycle.
REQ-007 Port b_valid, input, 1 bit, SHALL indicate source B offers b_data.
REQ-008 Port b_data, input, WIDTH bits, SHALL be source B payload.
REQ-009 Port b_ready, output, 1 bit, SHALL indicate source B is accepted this cycle.
REQ-010 Port out_valid, output, 1 bit, SHALL indicate out_data/sel hold a valid beat.
REQ-011 Port out_data, output, WIDTH bits, SHALL be the registered payload.
REQ-012 Port sel, output, 1 bit, SHALL be 1 when the held beat came from A and 0 when it came from B (the select that drives the downstream 2:1 mux).
REQ-013 Port out_ready, input, 1 bit, SHALL indicate downstream consumes the held beat this cycle.

Function
REQ-014 Internal state SHALL be one output register (out_valid, out_data, sel) plus a last_grant bit.
REQ-015 load = !out_valid | out_ready SHALL gate all acceptance; no beat accepted when load is 0.
REQ-016 Grant SHALL be: only A valid -> A; only B valid -> B; both valid -> the source not equal to last_grant; neither valid -> none.
REQ-017 a_ready SHALL be load & grant==A, b_ready SHALL be load & grant==B; both SHALL be combinational and never 1 together.
REQ-018 On transfer, out_data SHALL take the granted source data, sel the granted source, out_valid 1, and last_grant the granted source, all on the next edge (latency 1 cycle).
REQ-019 out_valid & out_ready with no transfer SHALL clear out_valid next cycle; out_data and sel SHALL then hold their last values.
REQ-020 Simultaneous out_ready and transfer SHALL replace the held beat with no bubble (full throughput, 1 beat/cycle).
REQ-021 out_valid & !out_ready SHALL hold out_data and sel stable and both readys at 0.
REQ-022 last_grant SHALL change only on a transfer; single-source transfers also update it.

Reset
REQ-023 rst_n low SHALL immediately force out_valid=0, out_data=0, sel=0, last_grant=B (so A wins the first tie).
REQ-024 Reset mid-operation SHALL discard any held beat; readys SHALL be 0 while rst_n is low.
REQ-025 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro RR_ARB2_ASSERT_EN defined SHALL compile in immediate assertions placed in always blocks separate from the RTL logic: readys mutually exclusive; out_data/sel stable while out_valid & !out_ready; a_ready implies a_valid; b_ready implies b_valid; each failure SHALL report via $error with a descriptive message.
REQ-027 Macro undefined SHALL produce no assertion code; RTL behaviour SHALL be identical and fully synthesizable either way.

Structure
REQ-028 Shared package synth_pkg SHALL hold typedef grant_t (GNT_B=0, GNT_A=1) and the default width constant DATA_W=8.
REQ-029 Combinational grant choice SHALL be a sub-module rr_pick2 (inputs a_valid, b_valid, last_grant; output grant and grant_vld).

Verification
REQ-030 Reset, then a_valid=1 a_data=8'h11, b_valid=1 b_data=8'h22, out_ready=1 -> cycle 1 out_data=8'h11 sel=1, cycle 2 8'h22 sel=0, alternating.
REQ-031 Only b_valid with b_data=8'h5A, out_ready=1 -> out_data=8'h5A sel=0 every cycle; a_ready=0 throughout.
REQ-032 Beat held (8'h33, sel=1), out_ready=0 for 3 cycles, both sources valid -> out_data stays 8'h33, a_ready=b_ready=0; on out_ready=1 next beat is B.
REQ-033 out_valid=1, out_ready=1, no source valid -> out_valid=0 next cycle, out_data unchanged.
REQ-034 rst_n pulsed low mid-stream with beat held -> out_valid=0, out_data=0, sel=0 immediately; after release a tie grants A first.
REQ-035 With RR_ARB2_ASSERT_EN defined, full random run with back-pressure -> zero assertion failures; forced a_ready and b_ready both 1 -> $error fires.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared types and constants for the two-source round-robin arbiter slice.
// The grant encoding matches the downstream mux select: 1 picks A, 0 picks B.
package synth_pkg;

  typedef enum logic {
    GNT_B = 1'b0,
    GNT_A = 1'b1
  } grant_t;

  localparam int DATA_W = 8;

endpackage : synth_pkg

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// and on a tie the source that did not win last time is chosen.
module rr_pick2
  import synth_pkg::*;
(
  input  logic   a_valid,
  input  logic   b_valid,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   grant_vld
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant     = GNT_B;
    grant_vld = a_valid | b_valid;
    if (a_valid && b_valid) begin
      grant = (last_grant == GNT_A) ? GNT_B : GNT_A;
    end else if (a_valid) begin
      grant = GNT_A;
    end
  end

endmodule : rr_pick2

// File: rtl/rr_arb2.sv
// Two-source round-robin arbiter feeding a single registered output stage.
// Define RR_ARB2_ASSERT_EN to compile in simulation-only protocol assertions.
module rr_arb2
  import synth_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  input  logic             out_ready
);

  grant_t last_grant;
  grant_t grant;
  logic   grant_vld;
  logic   load;
  logic   xfer;

  rr_pick2 u_pick (
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_vld  (grant_vld)
  );

  // The output register can take a new beat when empty or being drained now.
  assign load    = ~out_valid | out_ready;
  assign a_ready = rst_n & load & grant_vld & (grant == GNT_A);
  assign b_ready = rst_n & load & grant_vld & (grant == GNT_B);
  assign xfer    = a_ready | b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel        <= 1'b0;
      last_grant <= GNT_B;
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= (grant == GNT_A) ? a_data : b_data;
      sel        <= (grant == GNT_A);
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef RR_ARB2_ASSERT_EN
  logic             chk_hold;
  logic [WIDTH-1:0] chk_data;
  logic             chk_sel;

  // Snapshot of the beat as it stood on the previous edge, for stability checks.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_hold <= 1'b0;
      chk_data <= '0;
      chk_sel  <= 1'b0;
    end else begin
      chk_hold <= out_valid & ~out_ready;
      chk_data <= out_data;
      chk_sel  <= sel;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(a_ready && b_ready))
        else $error("rr_arb2: a_ready and b_ready asserted together");
      assert (!a_ready || a_valid)
        else $error("rr_arb2: a_ready asserted without a_valid");
      assert (!b_ready || b_valid)
        else $error("rr_arb2: b_ready asserted without b_valid");
      if (chk_hold) begin
        assert (out_data == chk_data && sel == chk_sel)
          else $error("rr_arb2: out_data/sel changed while beat stalled");
      end
    end
  end
`endif

endmodule : rr_arb2

// File: tb/tb_rr_arb2.sv
// Self-checking bench for rr_arb2: directed vector table, reset corner case,
// then a randomized run against a behavioural reference model.
module tb_rr_arb2;
  import synth_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         a_valid, b_valid, out_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, out_valid, sel;
  logic [W-1:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;

  rr_arb2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         av;
    logic [W-1:0] ad;
    logic         bv;
    logic [W-1:0] bd;
    logic         ordy;
    logic         ear;
    logic         ebr;
    logic         eov;
    logic [W-1:0] eod;
    logic         esel;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(logic av, logic [W-1:0] ad, logic bv, logic [W-1:0] bd,
                              logic ordy, logic ear, logic ebr, logic eov,
                              logic [W-1:0] eod, logic esel);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr; v.eov = eov; v.eod = eod; v.esel = esel;
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state: held beat plus which source won last.
  logic         m_valid, m_sel, m_last_a;
  logic [W-1:0] m_data;

  initial begin
    // Alternation on a tie, B-only stream, 3-cycle stall, drain, refill when empty.
    tbl[0]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 1);
    tbl[1]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 0);
    tbl[2]  = mk(1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 1);
    tbl[3]  = mk(1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 0);
    tbl[4]  = mk(0, 8'h00, 1, 8'h5A, 1,  0, 1,  1, 8'h5A, 0);
    tbl[5]  = mk(0, 8'h00, 1, 8'h5A, 1,  0, 1,  1, 8'h5A, 0);
    tbl[6]  = mk(1, 8'h33, 0, 8'h00, 1,  1, 0,  1, 8'h33, 1);
    tbl[7]  = mk(1, 8'h44, 1, 8'h66, 0,  0, 0,  1, 8'h33, 1);
    tbl[8]  = mk(1, 8'h44, 1, 8'h66, 0,  0, 0,  1, 8'h33, 1);
    tbl[9]  = mk(1, 8'h44, 1, 8'h66, 0,  0, 0,  1, 8'h33, 1);
    tbl[10] = mk(1, 8'h44, 1, 8'h66, 1,  0, 1,  1, 8'h66, 0);
    tbl[11] = mk(0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h66, 0);
    tbl[12] = mk(0, 8'h00, 0, 8'h00, 0,  0, 0,  0, 8'h66, 0);
    tbl[13] = mk(1, 8'h77, 0, 8'h00, 0,  1, 0,  1, 8'h77, 1);
    tbl[14] = mk(1, 8'h78, 0, 8'h00, 0,  0, 0,  1, 8'h77, 1);

    do_reset();
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data",  32'(out_data),  32'd0);
    check("reset_sel",       32'(sel),       32'd0);

    foreach (tbl[i]) begin
      a_valid = tbl[i].av; a_data = tbl[i].ad;
      b_valid = tbl[i].bv; b_data = tbl[i].bd;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_a_ready", i), 32'(a_ready), 32'(tbl[i].ear));
      check($sformatf("vec%0d_b_ready", i), 32'(b_ready), 32'(tbl[i].ebr));
      @(posedge clk); #1;
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      check($sformatf("vec%0d_out_data", i),  32'(out_data),  32'(tbl[i].eod));
      check($sformatf("vec%0d_sel", i),       32'(sel),       32'(tbl[i].esel));
    end

    // Reset mid-stream with a stalled beat: outputs clear without waiting for an edge.
    a_valid = 1'b1; a_data = 8'hC3; b_valid = 1'b1; b_data = 8'h3C; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data",  32'(out_data),  32'd0);
    check("midrst_sel",       32'(sel),       32'd0);
    check("midrst_a_ready",   32'(a_ready),   32'd0);
    check("midrst_b_ready",   32'(b_ready),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_a_ready", 32'(a_ready), 32'd1);
    check("postrst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    check("postrst_out_data", 32'(out_data), 32'hC3);
    check("postrst_sel",      32'(sel),      32'd1);

    // Randomized run with back-pressure against the reference model.
    do_reset();
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last_a = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      logic load, any, pick_a, ear, ebr;
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = W'($urandom);
      b_data    = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      load   = !m_valid || out_ready;
      any    = a_valid || b_valid;
      pick_a = (a_valid && b_valid) ? !m_last_a : a_valid;
      ear    = load && any && pick_a;
      ebr    = load && any && !pick_a;
      #1;
      check("rnd_a_ready", 32'(a_ready), 32'(ear));
      check("rnd_b_ready", 32'(b_ready), 32'(ebr));
      @(posedge clk); #1;
      if (ear || ebr) begin
        m_valid  = 1'b1;
        m_data   = pick_a ? a_data : b_data;
        m_sel    = pick_a;
        m_last_a = pick_a;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      check("rnd_out_valid", 32'(out_valid), 32'(m_valid));
      check("rnd_out_data",  32'(out_data),  32'(m_data));
      check("rnd_sel",       32'(sel),       32'(m_sel));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_arb2
